hawk_tblrd_arb: RTL and testbench

//  Arbitrates the single HAWK metadata AXI4 read channel between two requesters: the ATT lookup port (page manager) and the TOL list-entry port (compression manager).

---
 rtl/hawk_tblrd_arb_if.sv | 76 +++++++
 rtl/hawk_tblrd_arb.sv | 189 ++++++++++++++++++
 tb/tb_hawk_tblrd_arb.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/hawk_tblrd_arb_if.sv
// ----------------------------------------------------------------------------
// hawk_tblrd_arb_if
//   Bundle of every handshake and bus signal around the HAWK table-read
//   arbiter.
//   - master : the arbiter's view. It serves the ATT and list requesters and
//              is the AXI4 read master.
//   - slave  : the environment's view. That is the two requesters plus the
//              AXI4 read slave.
//
// Signal summary
//   att_req_vld/id/rdy  ATT lookup request (entry ID is 1-based)
//   att_rsp_vld/rdy     ATT response handshake
//   lst_req_vld/id/rdy  list-entry request (entry ID is 1-based)
//   lst_rsp_vld/rdy     list response handshake
//   rsp_data/rsp_err    returned line and error flag, shared by both responses
//   araddr/arvalid/arready/arlen/arid   AXI4 AR channel
//   rdata/rresp/rlast/rvalid/rready     AXI4 R channel
// ----------------------------------------------------------------------------
interface hawk_tblrd_arb_if #(
    parameter int AW      = 64,
    parameter int DW      = 512,
    parameter int ATT_IDW = 20,
    parameter int LST_IDW = 20
);
    // ATT requester
    logic               att_req_vld;
    logic [ATT_IDW-1:0] att_req_id;
    logic               att_req_rdy;
    logic               att_rsp_vld;
    logic               att_rsp_rdy;
    // list requester
    logic               lst_req_vld;
    logic [LST_IDW-1:0] lst_req_id;
    logic               lst_req_rdy;
    logic               lst_rsp_vld;
    logic               lst_rsp_rdy;
    // shared response payload
    logic [DW-1:0]      rsp_data;
    logic               rsp_err;
    // AXI4 AR channel
    logic [AW-1:0]      araddr;
    logic               arvalid;
    logic               arready;
    logic [7:0]         arlen;
    logic               arid;
    // AXI4 R channel
    logic [DW-1:0]      rdata;
    logic [1:0]         rresp;
    logic               rlast;
    logic               rvalid;
    logic               rready;

    modport master (
        input  att_req_vld, att_req_id, att_rsp_rdy,
        output att_req_rdy, att_rsp_vld,
        input  lst_req_vld, lst_req_id, lst_rsp_rdy,
        output lst_req_rdy, lst_rsp_vld,
        output rsp_data, rsp_err,
        output araddr, arvalid, arlen, arid,
        input  arready,
        input  rdata, rresp, rlast, rvalid,
        output rready
    );

    modport slave (
        output att_req_vld, att_req_id, att_rsp_rdy,
        input  att_req_rdy, att_rsp_vld,
        output lst_req_vld, lst_req_id, lst_rsp_rdy,
        input  lst_req_rdy, lst_rsp_vld,
        input  rsp_data, rsp_err,
        input  araddr, arvalid, arlen, arid,
        output arready,
        output rdata, rresp, rlast, rvalid,
        input  rready
    );
endinterface

// File: rtl/hawk_tblrd_arb.sv
// ----------------------------------------------------------------------------
// hawk_tblrd_arb
//   Shares the single HAWK metadata AXI4 read channel between the ATT lookup
//   port (page manager) and the TOL list-entry port (compression manager).
//   A granted entry ID is mapped to the byte address of the 64B line that
//   holds it. One single-beat read is then issued, and the whole line is
//   handed back to the requester that won. Only one transaction is in flight
//   at a time.
//
// Ports
//   clk_i   clock
//   rst_ni  asynchronous active-low reset
//   bus     hawk_tblrd_arb_if.master. This carries both requester
//           handshakes, the shared response payload and the AXI4 AR/R
//           channels.
//
// Parameters
//   AW, DW            AXI address / data width (DW is one cache line)
//   ATT_IDW, LST_IDW  entry ID widths of the two requesters
//   ATT_BASE          byte base of the ATT table (8 entries per line)
//   LST_BASE          byte base of the list table (4 entries per line)
// ----------------------------------------------------------------------------
module hawk_tblrd_arb #(
    parameter int            AW       = 64,
    parameter int            DW       = 512,
    parameter int            ATT_IDW  = 20,
    parameter int            LST_IDW  = 20,
    parameter logic [AW-1:0] ATT_BASE = AW'(64'h0000_0000_4000_0000),
    parameter logic [AW-1:0] LST_BASE = AW'(64'h0000_0000_8000_0000)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    hawk_tblrd_arb_if.master  bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_AR   = 2'd1,
        ST_R    = 2'd2,
        ST_RSP  = 2'd3
    } state_e;

    // Source encoding matches arid: 0 = ATT, 1 = list.
    localparam logic SRC_ATT = 1'b0;
    localparam logic SRC_LST = 1'b1;

    state_e         state_q, state_d;
    logic           src_q, src_d;          // owner of the current transaction
    logic           zero_q, zero_d;        // current transaction had illegal ID 0
    logic           last_q, last_d;        // last requester that was served
    logic [AW-1:0]  araddr_q, araddr_d;
    logic [DW-1:0]  rsp_data_q, rsp_data_d;
    logic           rsp_err_q, rsp_err_d;

    logic           att_rdy, lst_rdy;
    logic           any_req, grant_lst, grant_id_zero;
    logic [AW-1:0]  att_idx, lst_idx, att_addr, lst_addr;
    logic           unused_rlast;

    // ------------------------------------------------------------------------
    // Entry ID -> line address. The IDs are 1-based, so 1 is subtracted
    // first. The arithmetic is done at AW width, which means an overflow
    // wraps modulo 2^AW.
    // ------------------------------------------------------------------------
    assign att_idx  = AW'(bus.att_req_id) - AW'(1);
    assign lst_idx  = AW'(bus.lst_req_id) - AW'(1);
    assign att_addr = ATT_BASE + ((att_idx >> 3) << 6);
    assign lst_addr = LST_BASE + ((lst_idx >> 2) << 6);

    // ------------------------------------------------------------------------
    // Round-robin between two requesters. When both are asking, the one that
    // was not served last wins. last_q resets to list, so ATT takes the
    // first tie.
    // ------------------------------------------------------------------------
    assign any_req       = bus.att_req_vld | bus.lst_req_vld;
    assign grant_lst     = bus.lst_req_vld & (~bus.att_req_vld | (last_q == SRC_ATT));
    assign grant_id_zero = grant_lst ? (bus.lst_req_id == '0) : (bus.att_req_id == '0);

    // ------------------------------------------------------------------------
    // State and payload registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_IDLE;
            src_q      <= SRC_ATT;
            zero_q     <= 1'b0;
            last_q     <= SRC_LST;
            araddr_q   <= '0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            src_q      <= src_d;
            zero_q     <= zero_d;
            last_q     <= last_d;
            araddr_q   <= araddr_d;
            rsp_data_q <= rsp_data_d;
            rsp_err_q  <= rsp_err_d;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic and the request-ready strobes
    // ------------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        src_d      = src_q;
        zero_d     = zero_q;
        last_d     = last_q;
        araddr_d   = araddr_q;
        rsp_data_d = rsp_data_q;
        rsp_err_d  = rsp_err_q;
        att_rdy    = 1'b0;
        lst_rdy    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // The rst_ni term keeps both readys low while reset is held,
                // even if a requester is still presenting valid.
                if (rst_ni && any_req) begin
                    att_rdy = ~grant_lst;
                    lst_rdy = grant_lst;
                    src_d   = grant_lst;
                    zero_d  = grant_id_zero;
                    if (grant_id_zero) begin
                        // An illegal ID is answered locally with an error
                        // and an all-zero line. It passes through R with
                        // rready held low, so it never touches the bus.
                        rsp_data_d = '0;
                        rsp_err_d  = 1'b1;
                        state_d    = ST_R;
                    end else begin
                        araddr_d = grant_lst ? lst_addr : att_addr;
                        state_d  = ST_AR;
                    end
                end
            end

            ST_AR: begin
                if (bus.arready) begin
                    state_d = ST_R;
                end
            end

            ST_R: begin
                if (zero_q) begin
                    state_d = ST_RSP;
                end else if (bus.rvalid) begin
                    // The read is always single-beat (arlen = 0). The first
                    // R beat is therefore the whole answer, and rlast adds
                    // no information.
                    rsp_data_d = bus.rdata;
                    rsp_err_d  = (bus.rresp != 2'b00);
                    state_d    = ST_RSP;
                end
            end

            ST_RSP: begin
                if (src_q == SRC_LST ? bus.lst_rsp_rdy : bus.att_rsp_rdy) begin
                    last_d  = src_q;
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign bus.att_req_rdy = att_rdy;
    assign bus.lst_req_rdy = lst_rdy;
    assign bus.att_rsp_vld = (state_q == ST_RSP) && (src_q == SRC_ATT);
    assign bus.lst_rsp_vld = (state_q == ST_RSP) && (src_q == SRC_LST);
    assign bus.rsp_data    = rsp_data_q;
    assign bus.rsp_err     = rsp_err_q;

    assign bus.araddr      = araddr_q;
    assign bus.arvalid     = (state_q == ST_AR);
    assign bus.arlen       = 8'd0;
    assign bus.arid        = src_q;
    assign bus.rready      = (state_q == ST_R) && !zero_q;

    assign unused_rlast    = bus.rlast;

endmodule

// File: tb/tb_hawk_tblrd_arb.sv
module tb_hawk_tblrd_arb;

    localparam int            AW       = 64;
    localparam int            DW       = 512;
    localparam int            ATT_IDW  = 20;
    localparam int            LST_IDW  = 20;
    localparam logic [63:0]   ATT_BASE = 64'h0000_0000_1000_0000;
    localparam logic [63:0]   LST_BASE = 64'h0000_0000_2000_0000;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    hawk_tblrd_arb_if #(.AW(AW), .DW(DW), .ATT_IDW(ATT_IDW), .LST_IDW(LST_IDW)) bus ();

    hawk_tblrd_arb #(
        .AW(AW), .DW(DW), .ATT_IDW(ATT_IDW), .LST_IDW(LST_IDW),
        .ATT_BASE(ATT_BASE), .LST_BASE(LST_BASE)
    ) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1, "watchdog");
    end

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (bus.arlen !== 8'd0) begin
                n_fail++;
                $error("FAIL mon.arlen: observed %0h expected 0", bus.arlen);
            end
            if ((bus.att_req_rdy & bus.lst_req_rdy) !== 1'b0) begin
                n_fail++;
                $error("FAIL mon.dual_req_rdy: both request readys high");
            end
            if ((bus.att_rsp_vld & bus.lst_rsp_vld) !== 1'b0) begin
                n_fail++;
                $error("FAIL mon.dual_rsp_vld: both response valids high");
            end
            if ((bus.arvalid & bus.rready) !== 1'b0) begin
                n_fail++;
                $error("FAIL mon.ar_r_overlap: arvalid and rready high together");
            end
        end
    end

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    `define CHK(tag, obs, exp) chk(tag, 512'(obs), 512'(exp))

    // One complete transaction from a single requester. It starts shortly
    // after a falling edge and ends 1 time unit after a falling edge.
    task automatic txn(input bit lst, input logic [19:0] id, input logic [63:0] exp_addr,
                       input logic [511:0] data, input logic [1:0] resp,
                       input int ar_dly, input int rsp_dly, input string tag);
        if (lst) begin bus.lst_req_vld = 1'b1; bus.lst_req_id = id; end
        else     begin bus.att_req_vld = 1'b1; bus.att_req_id = id; end
        #1;
        `CHK({tag, ".req_rdy"},   lst ? bus.lst_req_rdy : bus.att_req_rdy, 1);
        `CHK({tag, ".other_rdy"}, lst ? bus.att_req_rdy : bus.lst_req_rdy, 0);
        @(negedge clk);
        bus.att_req_vld = 1'b0;
        bus.lst_req_vld = 1'b0;
        #1;
        `CHK({tag, ".arvalid"}, bus.arvalid, 1);
        `CHK({tag, ".araddr"},  bus.araddr, exp_addr);
        `CHK({tag, ".arid"},    bus.arid, lst);
        `CHK({tag, ".arlen"},   bus.arlen, 0);
        repeat (ar_dly) @(negedge clk);
        if (ar_dly > 0) begin
            #1;
            `CHK({tag, ".arvalid_held"}, bus.arvalid, 1);
            `CHK({tag, ".araddr_held"},  bus.araddr, exp_addr);
        end
        bus.arready = 1'b1;
        @(negedge clk);
        bus.arready = 1'b0;
        #1;
        `CHK({tag, ".rready"},    bus.rready, 1);
        `CHK({tag, ".arvalid_0"}, bus.arvalid, 0);
        bus.rvalid = 1'b1;
        bus.rdata  = data;
        bus.rresp  = resp;
        bus.rlast  = 1'b1;
        @(negedge clk);
        bus.rvalid = 1'b0;
        bus.rlast  = 1'b0;
        bus.rdata  = '0;
        bus.rresp  = 2'b00;
        #1;
        `CHK({tag, ".rsp_vld"},   lst ? bus.lst_rsp_vld : bus.att_rsp_vld, 1);
        `CHK({tag, ".other_vld"}, lst ? bus.att_rsp_vld : bus.lst_rsp_vld, 0);
        `CHK({tag, ".rsp_data"},  bus.rsp_data, data);
        `CHK({tag, ".rsp_err"},   bus.rsp_err, resp != 2'b00);
        repeat (rsp_dly) @(negedge clk);
        if (rsp_dly > 0) begin
            #1;
            `CHK({tag, ".rsp_vld_held"},  lst ? bus.lst_rsp_vld : bus.att_rsp_vld, 1);
            `CHK({tag, ".rsp_data_held"}, bus.rsp_data, data);
        end
        if (lst) bus.lst_rsp_rdy = 1'b1; else bus.att_rsp_rdy = 1'b1;
        @(negedge clk);
        bus.att_rsp_rdy = 1'b0;
        bus.lst_rsp_rdy = 1'b0;
        #1;
        `CHK({tag, ".rsp_vld_drop"}, lst ? bus.lst_rsp_vld : bus.att_rsp_vld, 0);
    endtask

    initial begin
        int          ngrant;
        bit          exp_lst;
        logic [63:0] att_addr_seen;

        n_tests = 0;
        n_fail  = 0;
        rst_n   = 1'b0;
        bus.att_req_vld = 1'b0; bus.att_req_id = '0; bus.att_rsp_rdy = 1'b0;
        bus.lst_req_vld = 1'b0; bus.lst_req_id = '0; bus.lst_rsp_rdy = 1'b0;
        bus.arready = 1'b0; bus.rdata = '0; bus.rresp = 2'b00;
        bus.rlast = 1'b0; bus.rvalid = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        `CHK("rst.arvalid",  bus.arvalid, 0);
        `CHK("rst.rready",   bus.rready, 0);
        `CHK("rst.araddr",   bus.araddr, 0);
        `CHK("rst.arid",     bus.arid, 0);
        `CHK("rst.rsp_data", bus.rsp_data, 0);
        `CHK("rst.rsp_err",  bus.rsp_err, 0);
        `CHK("rst.att_vld",  bus.att_rsp_vld, 0);
        `CHK("rst.lst_vld",  bus.lst_rsp_vld, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // T1: ATT id 1 maps to the table base
        txn(1'b0, 20'd1, ATT_BASE, {16{32'hCAFE_0001}}, 2'b00, 0, 0, "T1");

        // T2: address mapping, 8 ATT / 4 list entries per line
        txn(1'b0, 20'd9, ATT_BASE + 64'h40, {16{32'h0000_0009}}, 2'b00, 0, 0, "T2.att9");
        txn(1'b1, 20'd5, LST_BASE + 64'h40, {16{32'h5555_0005}}, 2'b00, 0, 0, "T2.lst5");
        txn(1'b1, 20'd4, LST_BASE,          {16{32'h4444_0004}}, 2'b00, 0, 0, "T2.lst4");

        // T3: both requesters held high; last served was list, so ATT goes first
        bus.att_req_vld = 1'b1; bus.att_req_id = 20'd3;
        bus.lst_req_vld = 1'b1; bus.lst_req_id = 20'd6;
        bus.arready = 1'b1; bus.rvalid = 1'b1; bus.rdata = {16{32'h3333_3333}};
        bus.rresp = 2'b00; bus.rlast = 1'b1;
        bus.att_rsp_rdy = 1'b1; bus.lst_rsp_rdy = 1'b1;
        ngrant  = 0;
        exp_lst = 1'b0;
        for (int c = 0; c < 40 && ngrant < 4; c++) begin
            #1;
            if (bus.att_req_rdy || bus.lst_req_rdy) begin
                `CHK("T3.grant_is_lst", bus.lst_req_rdy, exp_lst);
                `CHK("T3.single_grant", bus.att_req_rdy & bus.lst_req_rdy, 0);
                exp_lst = !exp_lst;
                ngrant++;
            end
            @(negedge clk);
        end
        `CHK("T3.grant_count", ngrant, 4);
        bus.att_req_vld = 1'b0;
        bus.lst_req_vld = 1'b0;
        repeat (4) @(negedge clk);
        bus.arready = 1'b0; bus.rvalid = 1'b0; bus.rlast = 1'b0; bus.rdata = '0;
        bus.att_rsp_rdy = 1'b0; bus.lst_rsp_rdy = 1'b0;
        @(negedge clk);

        // T4: SLVERR sets rsp_err; the following read is clean
        txn(1'b0, 20'd17, ATT_BASE + 64'h80, {16{32'hBAD0_0011}}, 2'b10, 0, 0, "T4.err");
        txn(1'b0, 20'd2,  ATT_BASE,          {16{32'h600D_0002}}, 2'b00, 0, 0, "T4.ok");

        // T5: illegal list ID 0 answers locally, two cycles after accept
        bus.lst_req_vld = 1'b1; bus.lst_req_id = 20'd0;
        #1;
        `CHK("T5.req_rdy", bus.lst_req_rdy, 1);
        @(negedge clk);
        bus.lst_req_vld = 1'b0;
        #1;
        `CHK("T5.c1.arvalid", bus.arvalid, 0);
        `CHK("T5.c1.rready",  bus.rready, 0);
        `CHK("T5.c1.rsp_vld", bus.lst_rsp_vld, 0);
        @(negedge clk);
        #1;
        `CHK("T5.c2.arvalid",  bus.arvalid, 0);
        `CHK("T5.c2.rsp_vld",  bus.lst_rsp_vld, 1);
        `CHK("T5.c2.att_vld",  bus.att_rsp_vld, 0);
        `CHK("T5.c2.rsp_err",  bus.rsp_err, 1);
        `CHK("T5.c2.rsp_data", bus.rsp_data, 0);
        bus.lst_rsp_rdy = 1'b1;
        @(negedge clk);
        bus.lst_rsp_rdy = 1'b0;
        #1;
        `CHK("T5.rsp_drop", bus.lst_rsp_vld, 0);

        // T6: stalled AR and response, then reset during R
        txn(1'b0, 20'd25, ATT_BASE + 64'hC0, {16{32'h7777_0019}}, 2'b00, 10, 5, "T6.stall");

        bus.att_req_vld = 1'b1; bus.att_req_id = 20'd1;
        @(negedge clk);
        bus.att_req_vld = 1'b0;
        #1;
        att_addr_seen = bus.araddr;
        `CHK("T6.pre.araddr", att_addr_seen, ATT_BASE);
        bus.arready = 1'b1;
        @(negedge clk);
        bus.arready = 1'b0;
        #1;
        `CHK("T6.pre.rready", bus.rready, 1);
        bus.lst_req_vld = 1'b1; bus.lst_req_id = 20'd2;
        rst_n = 1'b0;
        #1;
        `CHK("T6.rst.rready",   bus.rready, 0);
        `CHK("T6.rst.arvalid",  bus.arvalid, 0);
        `CHK("T6.rst.araddr",   bus.araddr, 0);
        `CHK("T6.rst.arid",     bus.arid, 0);
        `CHK("T6.rst.rsp_data", bus.rsp_data, 0);
        `CHK("T6.rst.rsp_err",  bus.rsp_err, 0);
        `CHK("T6.rst.lst_rdy",  bus.lst_req_rdy, 0);
        `CHK("T6.rst.att_vld",  bus.att_rsp_vld, 0);
        `CHK("T6.rst.lst_vld",  bus.lst_rsp_vld, 0);
        @(negedge clk);
        rst_n = 1'b1;
        txn(1'b1, 20'd2, LST_BASE, {16{32'h1234_5678}}, 2'b00, 0, 0, "T6.post");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        if (n_fail == 0) $display("PASS");
        else             $display("FAIL: %0d checks failed", n_fail);
        $finish;
    end

endmodule
